// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops words from a first-word-fall-through FIFO and sends each one as a serial frame:
// a start bit, the data bits LSB first, an optional even-parity bit and a stop bit.
module fifo_tx_serializer #(
    parameter int WIDTH        = 3,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] q_out,
    output logic             dequeue,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bit_idx, bit_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic             par, par_n;
    logic             tx_n, done_n, last;

    assign dequeue = state == IDLE && enable && !empty && reset;
    assign busy    = state != IDLE;
    assign last    = cnt == CNT_LAST;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            sh         <= '0;
            par        <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            sh         <= sh_n;
            par        <= par_n;
            tx         <= tx_n;
            frame_done <= done_n;
        end
    end

    // The cycle counter restarts at every bit boundary, so a one-cycle bit never has to wrap.
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || last) ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        par_n   = par;
        case (state)
            IDLE: if (dequeue) begin
                state_n = START;
                sh_n    = q_out;
                par_n   = ^q_out;
                bit_n   = '0;
            end
            START: if (last) state_n = DATA;
            DATA: if (last) begin
                if (bit_idx == BIT_LAST) state_n = PARITY_EN ? PARITY : STOP;
                else begin
                    bit_n = bit_idx + 1'b1;
                    sh_n  = sh >> 1;
                end
            end
            PARITY: if (last) state_n = STOP;
            STOP: if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered line moves in the same cycle as the state.
    always_comb begin
        tx_n   = state_n == START  ? 1'b0 :
                 state_n == DATA   ? sh_n[0] :
                 state_n == PARITY ? par_n : 1'b1;
        done_n = state_n == STOP && cnt_n == CNT_LAST;
    end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: Drives two serializer instances from FIFO models.
// One instance uses the default parameters and the other uses 8 bits at one cycle per bit.
module tb_fifo_tx_serializer;
    logic       clock = 0;
    logic       reset = 0;
    logic       enable_a = 0, enable_b = 0;
    logic       empty_a, empty_b;
    logic [2:0] q_a;
    logic [7:0] q_b;
    logic       deq_a, deq_b, tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [3:0] rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
    logic [1:0] exp_a [$];
    logic [1:0] exp_b [$];
    int         deq_t_a [$];
    int         deq_t_b [$];
    logic [1:0] ea, eb;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    fifo_tx_serializer dut_a (
        .clock(clock), .reset(reset), .enable(enable_a), .empty(empty_a), .q_out(q_a),
        .dequeue(deq_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
    );

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clock(clock), .reset(reset), .enable(enable_b), .empty(empty_b), .q_out(q_b),
        .dequeue(deq_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
    );

    assign empty_a = rd_a == wr_a;
    assign empty_b = rd_b == wr_b;
    assign q_a     = mem_a[rd_a][2:0];
    assign q_b     = mem_b[rd_b];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clock) cyc++;

    always @(posedge clock) begin
        if (deq_a) begin
            rd_a <= rd_a + 1;
            deq_t_a.push_back(cyc);
        end
        if (deq_b) begin
            rd_b <= rd_b + 1;
            deq_t_b.push_back(cyc);
        end
    end

    always @(negedge clock) begin
        if (busy_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_busy", 1, 0);
            else begin
                ea = exp_a.pop_front();
                chk("a_tx", tx_a, ea[1]);
                chk("a_frame_done", fd_a, ea[0]);
            end
        end else begin
            chk("a_idle_tx", tx_a, 1);
            chk("a_idle_frame_done", fd_a, 0);
        end
    end

    always @(negedge clock) begin
        if (busy_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_busy", 1, 0);
            else begin
                eb = exp_b.pop_front();
                chk("b_tx", tx_b, eb[1]);
                chk("b_frame_done", fd_b, eb[0]);
            end
        end else begin
            chk("b_idle_tx", tx_b, 1);
            chk("b_idle_frame_done", fd_b, 0);
        end
    end

    // bits holds the hand-written line levels of one frame, first bit in bit 0.
    task automatic load(input bit sel, input logic [7:0] d, input int nb, input logic [15:0] bits);
        int  cpb;
        bit  dn;
        cpb = sel ? 1 : 4;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < cpb; c++) begin
                dn = (b == nb - 1) && (c == cpb - 1);
                if (sel) exp_b.push_back({bits[b], dn});
                else exp_a.push_back({bits[b], dn});
            end
        if (sel) begin
            mem_b[wr_b] = d;
            wr_b = wr_b + 1;
        end else begin
            mem_a[wr_a] = d;
            wr_a = wr_a + 1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input bit sel, input int lim);
        int n = 0;
        while ((sel ? (exp_b.size() != 0 || busy_b) : (exp_a.size() != 0 || busy_a)) && n < lim) begin
            cycles(1);
            n++;
        end
        chk(sel ? "b_drain" : "a_drain", sel ? exp_b.size() : exp_a.size(), 0);
        cycles(2);
    endtask

    task automatic wait_busy_a(input bit level, input int lim);
        int n = 0;
        while (busy_a != level && n < lim) begin
            cycles(1);
            n++;
        end
        chk("a_wait_busy", busy_a, level);
    endtask

    initial begin
        int n;
        cycles(3);
        chk("reset_tx", tx_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_deq", deq_a, 0);
        reset = 1;
        cycles(2);
        // single word 101
        load(0, 8'h5, 6, 16'b101010);
        enable_a = 1;
        drain(0, 60);
        chk("t1_deq_count", deq_t_a.size(), 1);
        // parity of 110 and 111
        load(0, 8'h6, 6, 16'b101100);
        load(0, 8'h7, 6, 16'b111110);
        drain(0, 100);
        chk("t2_deq_count", deq_t_a.size(), 3);
        // back-to-back 001, 010, 100
        n = deq_t_a.size();
        load(0, 8'h1, 6, 16'b110010);
        load(0, 8'h2, 6, 16'b110100);
        load(0, 8'h4, 6, 16'b111000);
        drain(0, 150);
        chk("t3_deq_count", deq_t_a.size(), n + 3);
        if (deq_t_a.size() == n + 3) begin
            chk("t3_period_1", deq_t_a[n+1] - deq_t_a[n], 25);
            chk("t3_period_2", deq_t_a[n+2] - deq_t_a[n+1], 25);
        end
        // gating: enable low with data waiting
        enable_a = 0;
        n = deq_t_a.size();
        load(0, 8'h3, 6, 16'b100110);
        load(0, 8'h2, 6, 16'b110100);
        cycles(50);
        chk("t4_enable_low_deq", deq_t_a.size(), n);
        enable_a = 1;
        wait_busy_a(1, 10);
        cycles(10);
        enable_a = 0;
        wait_busy_a(0, 40);
        cycles(10);
        chk("t4_drop_enable_deq", deq_t_a.size(), n + 1);
        chk("t4_pending_frame", exp_a.size(), 24);
        // reset in the middle of the data bits
        enable_a = 1;
        wait_busy_a(1, 10);
        cycles(6);
        #1 reset = 0;
        exp_a.delete();
        #1;
        chk("t5_reset_tx", tx_a, 1);
        chk("t5_reset_busy", busy_a, 0);
        chk("t5_reset_frame_done", fd_a, 0);
        chk("t5_reset_deq", deq_a, 0);
        n = deq_t_a.size();
        load(0, 8'h7, 6, 16'b111110);
        cycles(3);
        reset = 1;
        drain(0, 60);
        chk("t5_fresh_deq", deq_t_a.size(), n + 1);
        // enabled with the FIFO empty
        n = deq_t_a.size();
        cycles(30);
        chk("t4_empty_deq", deq_t_a.size(), n);
        chk("t4_empty_busy", busy_a, 0);
        // 8-bit, one cycle per bit, no parity: A5 then 3C
        load(1, 8'hA5, 10, 16'b1101001010);
        load(1, 8'h3C, 10, 16'b1001111000);
        enable_b = 1;
        drain(1, 60);
        chk("t6_deq_count", deq_t_b.size(), 2);
        if (deq_t_b.size() == 2) chk("t6_period", deq_t_b[1] - deq_t_b[0], 11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
